alu_serial: RTL
===============

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, giving the bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, and N = WIDTH/SLICE.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-007 The block SHALL have port ctrl, input, 4 bits: operation code, sampled with start.
REQ-008 The block SHALL have ports src1 and src2, input, WIDTH bits each: operands, sampled with start.
REQ-009 The block SHALL have port result, output, WIDTH bits: registered result.
REQ-010 The block SHALL have ports zero, cout and overflow, output, 1 bit each: registered flags.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The opcodes SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100 and NAND 1101; any other code SHALL produce result 0 with zero=1 and cout=overflow=0.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset SHALL force IDLE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture ctrl, src1 and src2, clear the slice counter, and enter RUN; start in RUN SHALL be ignored.
REQ-016 RUN SHALL process one SLICE-bit slice per cycle, least-significant slice first, using the carry registered from the previous slice, for exactly N cycles.
REQ-017 On the Nth RUN edge the FSM SHALL enter DONE, update result and all flags, and assert done for exactly one cycle.
REQ-018 DONE SHALL return to IDLE when start=0, or re-enter RUN when start=1, which gives back-to-back operation with one DONE cycle between results.
REQ-019 Latency SHALL be N rising edges from the accepting edge to done high.
REQ-020 busy SHALL be high exactly while in RUN.
REQ-021 result and the flags SHALL hold their value from DONE until the next DONE, and SHALL NOT show partial slices.
REQ-022 SUB and SLT SHALL compute src1 + ~src2 with carry-in 1 at slice 0; ADD SHALL use carry-in 0.
REQ-023 For ADD and SUB, cout SHALL be the carry out of bit WIDTH-1 (for SUB, 1 means no borrow).
REQ-024 For ADD and SUB, overflow SHALL be the signed two's-complement overflow.
REQ-025 For logical ops and SLT, cout and overflow SHALL be 0.
REQ-026 For SLT, result SHALL be zero-extended (sign bit of difference XOR subtraction overflow), so the signed comparison is correct even when the subtraction overflows.
REQ-027 zero SHALL be 1 exactly when the final result equals 0.
REQ-028 With N=1 (SLICE=WIDTH) the block SHALL behave identically, with latency 1.

Reset
REQ-029 When rst_n=0, regardless of clk, the block SHALL set state IDLE and clear result, zero, cout, overflow, busy, done, the slice counter and the carry to 0.
REQ-030 Reset asserted during RUN SHALL abort the operation with no done pulse, and no stale result SHALL appear after release.
REQ-031 The first rising edge with rst_n=1 SHALL be able to accept start.

Verification (WIDTH=32, SLICE=8, N=4)
REQ-032 ADD with src1=0x7FFFFFFF, src2=0x00000001 -> done 4 edges after accept; result 0x80000000, overflow=1, cout=0, zero=0; busy high for 4 cycles.
REQ-033 SUB with src1=src2=5 -> result 0, zero=1, cout=1, overflow=0; ADD with 0xFFFFFFFF+1 -> result 0, cout=1, zero=1.
REQ-034 SLT with src1=0x80000000, src2=1 -> result 1; SLT with src1=1, src2=0x80000000 -> result 0; cout=overflow=0 in both cases.
REQ-035 NOR with 0,0 -> 0xFFFFFFFF; NAND with 0xFFFFFFFF,0xFFFFFFFF -> 0, zero=1; ctrl=1111 -> result 0, zero=1.
REQ-036 start pulsed in the 2nd RUN cycle -> ignored and first result unchanged; start held during DONE -> second operation accepted, with a second done 4 edges later.
REQ-037 rst_n low in the 3rd RUN cycle -> busy, done and result immediately 0; no done pulse after release; a fresh ADD 2+3 then -> result 5.

Source files
------------

// File: rtl/alu_serial.sv
// Bit-serial ALU: processes SLICE bits per cycle, LSB slice first, and presents the
// complete result plus flags only once all N = WIDTH/SLICE slices are done.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin an operation (accepted in IDLE or DONE, ignored in RUN)
//   ctrl      opcode, sampled with start
//   src1/src2 operands, sampled with start
//   result    registered result, held between completions
//   zero      result == 0
//   cout      carry out of the MSB (ADD/SUB only)
//   overflow  signed overflow (ADD/SUB only)
//   busy      high while in RUN
//   done      one-cycle pulse when result/flags update
module alu_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpNand = 4'b1101;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for SUB/SLT
    logic [WIDTH-1:0] acc_q;    // partial result, slices shift in from the top
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic             sub_in;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE:0]   sum_s;
    logic             ov_s;
    logic             arith;
    logic [SLICE-1:0] slice_res;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] res_fin;
    logic             cout_fin;
    logic             ov_fin;

    assign sub_in = (ctrl == OpSub) || (ctrl == OpSlt);

    always_comb begin
        a_s       = a_q[SLICE-1:0];
        b_s       = b_q[SLICE-1:0];
        sum_s     = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        // Only meaningful on the last slice, where the MSBs are the operand sign bits.
        ov_s      = (a_s[SLICE-1] == b_s[SLICE-1]) && (sum_s[SLICE-1] != a_s[SLICE-1]);
        arith     = 1'b0;
        slice_res = '0;
        case (ctrl_q)
            OpAnd:  slice_res = a_s & b_s;
            OpOr:   slice_res = a_s | b_s;
            OpNor:  slice_res = ~(a_s | b_s);
            OpNand: slice_res = ~(a_s & b_s);
            OpAdd, OpSub: begin
                slice_res = sum_s[SLICE-1:0];
                arith     = 1'b1;
            end
            OpSlt:  slice_res = sum_s[SLICE-1:0];
            default: slice_res = '0;
        endcase
        acc_next = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
        // SLT: sign of difference corrected by overflow gives the true signed compare.
        res_fin  = (ctrl_q == OpSlt) ? {{(WIDTH-1){1'b0}}, sum_s[SLICE-1] ^ ov_s} : acc_next;
        cout_fin = arith & sum_s[SLICE];
        ov_fin   = arith & ov_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        ctrl_q  <= ctrl;
                        a_q     <= src1;
                        b_q     <= sub_in ? ~src2 : src2;
                        carry_q <= sub_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    carry_q <= sum_s[SLICE];
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        result_q   <= res_fin;
                        zero_q     <= (res_fin == '0);
                        cout_q     <= cout_fin;
                        overflow_q <= ov_fin;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
